// File: rtl/mipi_periph_pkg.sv
// Shared types and constants for the MIPI peripheral TX response streamer.
package mipi_periph_pkg;

    localparam logic [5:0] DT_ACK_ERR  = 6'h02;
    localparam logic [5:0] DT_SHORT1   = 6'h21;
    localparam logic [5:0] DT_SHORT2   = 6'h22;
    localparam logic [5:0] DT_LONG_DCS = 6'h1C;
    localparam logic [5:0] DT_LONG_GEN = 6'h1A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REQ    = 2'd2,
        STREAM = 2'd3
    } state_e;

    localparam int unsigned ERR_OVERRUN    = 0;
    localparam int unsigned ERR_UNDERRUN   = 1;
    localparam int unsigned ERR_LEN        = 2;
    localparam int unsigned ERR_WR_BLOCKED = 3;
    localparam int unsigned ERR_TIMEOUT    = 4;
    localparam int unsigned ERR_W          = 5;

    function automatic logic is_short_dt(input logic [5:0] dt);
        return (dt == DT_ACK_ERR) || (dt == DT_SHORT1) || (dt == DT_SHORT2);
    endfunction

    // Zero the byte lanes past the end of the payload in the final word.
    function automatic logic [31:0] pad_last_word(input logic [31:0] w, input logic [1:0] rem);
        logic [31:0] r;
        case (rem)
            2'd1:    r = {24'h0, w[7:0]};
            2'd2:    r = {16'h0, w[15:0]};
            2'd3:    r = {8'h0, w[23:0]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mipi_tx_payload_buf.sv
// Payload word buffer: DEPTH x 32 registers, one write port, asynchronous read.
module mipi_tx_payload_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [DEPTH];

    // Out-of-range addresses are dropped on write and read back as zero.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : 32'h0;

endmodule

// File: rtl/mipi_periph_tx_streamer.sv
// DCS read-response streamer: waits for bus turnaround, requests TX, streams payload words.
// Optional build macro PAYLOAD_PAD_EN zeroes bytes past byte_count in the final word.
module mipi_periph_tx_streamer
    import mipi_periph_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic             clk_periph,
    input  logic             rstn,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [5:0]       rsp_data_type,
    input  logic [15:0]      rsp_byte_count,
    input  logic             buf_wr_en,
    input  logic [AW-1:0]    buf_wr_addr,
    input  logic [31:0]      buf_wr_data,
    input  logic             mipi_periph_tx_payload_en,
    input  logic             mipi_periph_tx_payload_en_last,
    input  logic             mipi_periph_tx_cmd_ack,
    input  logic             mipi_periph_dphy_direction,
    output logic [31:0]      mipi_periph_tx_payload,
    output logic [1:0]       mipi_periph_tx_cmd_vc,
    output logic [5:0]       mipi_periph_tx_cmd_data_type,
    output logic [15:0]      mipi_periph_tx_cmd_byte_count,
    output logic             mipi_periph_tx_cmd_req,
    output logic             busy,
    output logic [ERR_W-1:0] err_flags,
    input  logic             err_clr
);

    localparam int unsigned IW        = AW + 1;
    localparam int unsigned TW        = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned MAX_BYTES = DEPTH * 4;

    state_e            state_q, state_d;
    logic              pe_q, last_q, ack_q;
    logic              dir_s_q, dir_d1_q, dir_d2_q;
    logic [5:0]        dt_q, dt_d;
    logic [15:0]       bc_q, bc_d;
    logic              long_q, long_d;
    logic [IW-1:0]     nwords_q, nwords_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              req_q, req_d;
    logic              rsp_ready_q, rsp_ready_d;
    logic              busy_q, busy_d;
    logic [31:0]       payload_q, payload_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic              fall_c, rsp_long_c, rsp_len_bad_c, tmo_hit_c, buf_we_c;
    logic [IW-1:0]     nxt_idx_c;
    logic [AW-1:0]     rd_addr_c;
    logic [31:0]       rd_data_c, nxt_word_c;

    mipi_tx_payload_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk     (clk_periph),
        .wr_en   (buf_we_c),
        .wr_addr (buf_wr_addr),
        .wr_data (buf_wr_data),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data_c)
    );

    // IP handshake inputs; direction gets an extra stage for the turnaround edge.
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            pe_q     <= 1'b0;
            last_q   <= 1'b0;
            ack_q    <= 1'b0;
            dir_s_q  <= 1'b0;
            dir_d1_q <= 1'b0;
            dir_d2_q <= 1'b0;
        end else begin
            pe_q     <= mipi_periph_tx_payload_en;
            last_q   <= mipi_periph_tx_payload_en_last;
            ack_q    <= mipi_periph_tx_cmd_ack;
            dir_s_q  <= mipi_periph_dphy_direction;
            dir_d1_q <= dir_s_q;
            dir_d2_q <= dir_d1_q;
        end
    end

    always_comb begin
        fall_c        = dir_d2_q & ~dir_d1_q;
        rsp_long_c    = !is_short_dt(rsp_data_type) && (rsp_byte_count != 16'd0);
        rsp_len_bad_c = rsp_long_c && (32'(rsp_byte_count) > MAX_BYTES);
        tmo_hit_c     = (tmo_q == TW'(ACK_TIMEOUT - 1));
        buf_we_c      = buf_wr_en && (state_q == IDLE);
        nxt_idx_c     = (state_q == REQ) ? '0 : idx_q + IW'(1);
        rd_addr_c     = AW'(nxt_idx_c);
`ifdef PAYLOAD_PAD_EN
        nxt_word_c = (nxt_idx_c == nwords_q - IW'(1)) ? pad_last_word(rd_data_c, bc_q[1:0])
                                                      : rd_data_c;
`else
        nxt_word_c = rd_data_c;
`endif
    end

    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (rsp_valid && !rsp_len_bad_c) state_d = ARMED;
            ARMED:  if (fall_c) state_d = REQ;
            REQ: begin
                if (ack_q) begin
                    state_d = long_q ? STREAM : IDLE;
                end else if (tmo_hit_c) begin
                    state_d = IDLE;
                end
            end
            STREAM: if (pe_q && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dt_d        = dt_q;
        bc_d        = bc_q;
        long_d      = long_q;
        nwords_d    = nwords_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        req_d       = req_q;
        payload_d   = payload_q;
        rsp_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        err_d       = err_clr ? '0 : err_q;

        if (buf_wr_en && (state_q != IDLE)) err_d[ERR_WR_BLOCKED] = 1'b1;

        case (state_q)
            IDLE: begin
                if (rsp_valid) begin
                    if (rsp_len_bad_c) begin
                        err_d[ERR_LEN] = 1'b1;
                    end else begin
                        dt_d     = rsp_data_type;
                        bc_d     = rsp_byte_count;
                        long_d   = rsp_long_c;
                        nwords_d = IW'((17'(rsp_byte_count) + 17'd3) >> 2);
                    end
                end
            end
            ARMED: begin
                if (fall_c) begin
                    req_d = 1'b1;
                    tmo_d = '0;
                end
            end
            REQ: begin
                if (ack_q) begin
                    req_d = 1'b0;
                    if (long_q) begin
                        idx_d     = '0;
                        payload_d = nxt_word_c;
                    end
                end else if (tmo_hit_c) begin
                    req_d              = 1'b0;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            STREAM: begin
                if (pe_q) begin
                    if (idx_q >= nwords_q) begin
                        err_d[ERR_OVERRUN] = 1'b1;
                        payload_d          = '0;
                    end else begin
                        idx_d     = nxt_idx_c;
                        payload_d = (nxt_idx_c < nwords_q) ? nxt_word_c : '0;
                        if (last_q && (nxt_idx_c < nwords_q)) err_d[ERR_UNDERRUN] = 1'b1;
                    end
                    if (last_q) payload_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            dt_q        <= '0;
            bc_q        <= '0;
            long_q      <= 1'b0;
            nwords_q    <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            req_q       <= 1'b0;
            rsp_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            payload_q   <= '0;
            err_q       <= '0;
        end else begin
            dt_q        <= dt_d;
            bc_q        <= bc_d;
            long_q      <= long_d;
            nwords_q    <= nwords_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            req_q       <= req_d;
            rsp_ready_q <= rsp_ready_d;
            busy_q      <= busy_d;
            payload_q   <= payload_d;
            err_q       <= err_d;
        end
    end

    assign rsp_ready                     = rsp_ready_q;
    assign busy                          = busy_q;
    assign err_flags                     = err_q;
    assign mipi_periph_tx_payload        = payload_q;
    assign mipi_periph_tx_cmd_vc         = 2'b00;
    assign mipi_periph_tx_cmd_data_type  = dt_q;
    assign mipi_periph_tx_cmd_byte_count = bc_q;
    assign mipi_periph_tx_cmd_req        = req_q;

endmodule
